// File: rtl/core_dbg_pkg.sv
// core_dbg_pkg: register map, CTRL/STATUS bit positions and FSM states for the core debug MEMI responder
package core_dbg_pkg;
   localparam int unsigned REG_ID     = 0;
   localparam int unsigned REG_CTRL   = 1;
   localparam int unsigned REG_STATUS = 2;
   localparam int unsigned REG_DTR_TX = 3;
   localparam int unsigned REG_DTR_RX = 4;
   localparam int unsigned REG_INSN   = 5;
   localparam int unsigned CTRL_HALT       = 0;
   localparam int unsigned CTRL_RESUME     = 1;
   localparam int unsigned CTRL_STEP       = 2;
   localparam int unsigned CTRL_CLR_STICKY = 31;
   localparam int unsigned ST_HALTED   = 0;
   localparam int unsigned ST_TX_VALID = 1;
   localparam int unsigned ST_RX_VALID = 2;
   localparam int unsigned ST_TX_OVR   = 3;
   localparam int unsigned ST_INSN_ERR = 4;
   localparam int unsigned ST_RX_TO    = 5;
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_RX, RESP} state_e;
endpackage

// File: rtl/dbg_mailbox.sv
// dbg_mailbox: single-entry holding register with valid/ack handshake and sticky overrun flag
// Ports: clk_i/rst_n_i clock and async active-low reset; wr_i/data_i load request; ack_i consumer ack;
//        clr_ovr_i clears overrun; data_o/valid_o held entry; ovr_o set when a load hits a full entry.
module dbg_mailbox #(
   parameter int unsigned DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          wr_i,
   input  logic [DW-1:0] data_i,
   input  logic          ack_i,
   input  logic          clr_ovr_i,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   output logic          ovr_o
);
   logic [DW-1:0] data_q;
   logic          valid_q, ovr_q;
   // An ack landing together with a load frees the entry, so the load wins without overrun.
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (wr_i && valid_q && !ack_i) ovr_q <= 1'b1;
         else if (wr_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
         end else if (ack_i) valid_q <= 1'b0;
         if (clr_ovr_i) ovr_q <= 1'b0;
      end
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ovr_o   = ovr_q;
endmodule

// File: rtl/core_dbg_memi_responder.sv
// core_dbg_memi_responder: MEMI slave decoding debug-port accesses into a per-core debug register file
// Ports: memi_* APB-like request/response from the debug initiator; core_halted_i / dbg_*_req_o run control;
//        dtr_tx_* debugger->core mailbox; dtr_rx_* core->debugger mailbox; insn_* instruction injection.
module core_dbg_memi_responder
   import core_dbg_pkg::*;
#(
   parameter int unsigned                     MEMI_ADDR_WIDTH  = 5,
   parameter int unsigned                     MEMI_DATA_WIDTH  = 32,
   parameter logic [MEMI_DATA_WIDTH-1:0]      ID_VALUE         = 32'hDC0D_0001,
   parameter int unsigned                     RX_TIMEOUT       = 64,
   parameter logic [MEMI_DATA_WIDTH-1:0]      RX_TIMEOUT_VALUE = 32'hDEAD_DEAD
) (
   input  logic                       memi_clk_i,
   input  logic                       memi_rst_n_i,
   input  logic                       memi_sel_i,
   input  logic [MEMI_ADDR_WIDTH-1:0] memi_addr_i,
   input  logic                       memi_wr_rd_i,
   input  logic [MEMI_DATA_WIDTH-1:0] memi_wdata_i,
   output logic [MEMI_DATA_WIDTH-1:0] memi_rdata_o,
   output logic                       memi_ready_o,
   input  logic                       core_halted_i,
   output logic                       dbg_halt_req_o,
   output logic                       dbg_resume_req_o,
   output logic                       dbg_step_req_o,
   output logic [MEMI_DATA_WIDTH-1:0] dtr_tx_data_o,
   output logic                       dtr_tx_valid_o,
   input  logic                       dtr_tx_ack_i,
   input  logic [MEMI_DATA_WIDTH-1:0] dtr_rx_data_i,
   input  logic                       dtr_rx_valid_i,
   output logic                       dtr_rx_ack_o,
   output logic [MEMI_DATA_WIDTH-1:0] insn_data_o,
   output logic                       insn_valid_o,
   input  logic                       insn_ack_i
);
   localparam int unsigned AW = MEMI_ADDR_WIDTH;
   localparam int unsigned DW = MEMI_DATA_WIDTH;
   localparam int unsigned CW = $clog2(RX_TIMEOUT + 1);
   state_e          state_q;
   logic            sel_q, wr_q, ready_q, halt_q, resume_q, step_q, insn_valid_q, insn_err_q, rx_to_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q, rdata_q, rdata_d, status, insn_data_q;
   logic [CW-1:0]   cnt_q;
   logic            acc_wr, tx_wr, clr_sticky, rx_take, tx_ovr, rx_ack;
   logic [DW-1:0]   unused_rx_data;
   logic            unused_rx_ovr;
   assign acc_wr     = state_q == ACCESS && wr_q;
   assign tx_wr      = acc_wr && addr_q == AW'(REG_DTR_TX);
   assign clr_sticky = acc_wr && addr_q == AW'(REG_CTRL) && wdata_q[CTRL_CLR_STICKY];
   // Core data is taken on the edge into RESP, from ACCESS directly or from WAIT_RX.
   assign rx_take    = dtr_rx_valid_i &&
                       (state_q == WAIT_RX || (state_q == ACCESS && !wr_q && addr_q == AW'(REG_DTR_RX)));
   always_comb begin
      status              = '0;
      status[ST_HALTED]   = core_halted_i;
      status[ST_TX_VALID] = dtr_tx_valid_o;
      status[ST_RX_VALID] = dtr_rx_valid_i;
      status[ST_TX_OVR]   = tx_ovr;
      status[ST_INSN_ERR] = insn_err_q;
      status[ST_RX_TO]    = rx_to_q;
   end
   assign rdata_d = addr_q == AW'(REG_ID)     ? ID_VALUE      :
                    addr_q == AW'(REG_CTRL)   ? DW'(halt_q)   :
                    addr_q == AW'(REG_STATUS) ? status        :
                    addr_q == AW'(REG_DTR_RX) ? dtr_rx_data_i : '0;
   always_ff @(posedge memi_clk_i or negedge memi_rst_n_i)
      if (!memi_rst_n_i) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b0;
         halt_q       <= 1'b0;
         resume_q     <= 1'b0;
         step_q       <= 1'b0;
         insn_valid_q <= 1'b0;
         insn_data_q  <= '0;
         insn_err_q   <= 1'b0;
         rx_to_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sel_q    <= memi_sel_i;
         ready_q  <= 1'b0;
         resume_q <= 1'b0;
         step_q   <= 1'b0;
         if (core_halted_i) halt_q <= 1'b0;
         if (insn_ack_i) insn_valid_q <= 1'b0;
         if (clr_sticky) begin
            insn_err_q <= 1'b0;
            rx_to_q    <= 1'b0;
         end
         case (state_q)
            // Request fields are only guaranteed for two cycles, so they are captured on the sel edge.
            IDLE: if (memi_sel_i && !sel_q) begin
               addr_q  <= memi_addr_i;
               wr_q    <= memi_wr_rd_i;
               wdata_q <= memi_wdata_i;
               state_q <= SETUP;
            end
            SETUP: state_q <= ACCESS;
            ACCESS: begin
               cnt_q <= '0;
               if (wr_q) begin
                  if (addr_q == AW'(REG_CTRL)) begin
                     resume_q <= wdata_q[CTRL_RESUME];
                     step_q   <= wdata_q[CTRL_STEP];
                     if (wdata_q[CTRL_RESUME]) halt_q <= 1'b0;
                     else if (wdata_q[CTRL_HALT]) halt_q <= 1'b1;
                  end
                  if (addr_q == AW'(REG_INSN)) begin
                     if (core_halted_i && !insn_valid_q) begin
                        insn_data_q  <= wdata_q;
                        insn_valid_q <= 1'b1;
                     end else insn_err_q <= 1'b1;
                  end
                  state_q <= RESP;
                  ready_q <= 1'b1;
               end else if (addr_q == AW'(REG_DTR_RX) && !dtr_rx_valid_i) state_q <= WAIT_RX;
               else begin
                  rdata_q <= rdata_d;
                  state_q <= RESP;
                  ready_q <= 1'b1;
               end
            end
            WAIT_RX: begin
               cnt_q <= cnt_q + 1'b1;
               if (dtr_rx_valid_i || cnt_q == CW'(RX_TIMEOUT - 1)) begin
                  rdata_q <= dtr_rx_valid_i ? dtr_rx_data_i : RX_TIMEOUT_VALUE;
                  if (!dtr_rx_valid_i) rx_to_q <= 1'b1;
                  state_q <= RESP;
                  ready_q <= 1'b1;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   dbg_mailbox #(.DW(DW)) u_tx (
      .clk_i    (memi_clk_i),
      .rst_n_i  (memi_rst_n_i),
      .wr_i     (tx_wr),
      .data_i   (wdata_q),
      .ack_i    (dtr_tx_ack_i),
      .clr_ovr_i(clr_sticky),
      .data_o   (dtr_tx_data_o),
      .valid_o  (dtr_tx_valid_o),
      .ovr_o    (tx_ovr)
   );
   // Self-acknowledging: the entry is full only during RESP, which yields the one-cycle core ack.
   dbg_mailbox #(.DW(DW)) u_rx (
      .clk_i    (memi_clk_i),
      .rst_n_i  (memi_rst_n_i),
      .wr_i     (rx_take),
      .data_i   (dtr_rx_data_i),
      .ack_i    (rx_ack),
      .clr_ovr_i(1'b0),
      .data_o   (unused_rx_data),
      .valid_o  (rx_ack),
      .ovr_o    (unused_rx_ovr)
   );
   assign memi_rdata_o     = rdata_q;
   assign memi_ready_o     = ready_q;
   assign dbg_halt_req_o   = halt_q;
   assign dbg_resume_req_o = resume_q;
   assign dbg_step_req_o   = step_q;
   assign dtr_rx_ack_o     = rx_ack;
   assign insn_data_o      = insn_data_q;
   assign insn_valid_o     = insn_valid_q;
endmodule

// File: tb/tb_core_dbg_memi_responder.sv
// tb_core_dbg_memi_responder: scoreboard bench for the core debug MEMI responder
module tb_core_dbg_memi_responder;
   localparam logic [4:0] A_ID = 5'd0, A_CTRL = 5'd1, A_STATUS = 5'd2, A_TX = 5'd3, A_RX = 5'd4, A_INSN = 5'd5;
   logic clk = 0, rst_n = 0, sel = 0, wr = 0, core_halted = 0, tx_ack = 0, rx_valid = 0, insn_ack = 0;
   logic [4:0] addr = '0;
   logic [31:0] wdata = '0, rx_data = '0;
   logic [31:0] rdata, tx_data, insn_data;
   logic ready, halt, resume, step, tx_valid, rx_ack, insn_valid;
   typedef struct packed {logic rd; logic [31:0] d;} sb_t;
   sb_t sb_q[$];
   int errors = 0, checks = 0, n_ready = 0, n_rxack = 0, n_resume = 0, n_step = 0;
   core_dbg_memi_responder dut (
      .memi_clk_i(clk), .memi_rst_n_i(rst_n), .memi_sel_i(sel), .memi_addr_i(addr),
      .memi_wr_rd_i(wr), .memi_wdata_i(wdata), .memi_rdata_o(rdata), .memi_ready_o(ready),
      .core_halted_i(core_halted), .dbg_halt_req_o(halt), .dbg_resume_req_o(resume),
      .dbg_step_req_o(step), .dtr_tx_data_o(tx_data), .dtr_tx_valid_o(tx_valid),
      .dtr_tx_ack_i(tx_ack), .dtr_rx_data_i(rx_data), .dtr_rx_valid_i(rx_valid),
      .dtr_rx_ack_o(rx_ack), .insn_data_o(insn_data), .insn_valid_o(insn_valid), .insn_ack_i(insn_ack)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      sb_t e;
      if (ready) begin
         n_ready++;
         chk("sb_pending", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.rd) chk("rdata", rdata, e.d);
         end
      end
      if (rx_ack) n_rxack++;
      if (resume) n_resume++;
      if (step) n_step++;
   end
   task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp,
                       input int exp_lat, input string tag, output int lat);
      sb_t e;
      e.rd = !w;
      e.d  = exp;
      sb_q.push_back(e);
      @(posedge clk); #1;
      sel = 1; addr = a; wr = w; wdata = d; lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) begin
            sel = 0; addr = 5'h1f; wdata = 32'hFFFF_FFFF; wr = !w;
         end
      end while (!ready && lat < 200);
      sel = 0;
      chk({tag, "_ready"}, ready, 1);
      if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, ready, 0);
   endtask
   task automatic pulse_tx_ack();
      @(posedge clk); #1 tx_ack = 1;
      @(posedge clk); #1 tx_ack = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      int lat, n0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", {ready, halt, resume, step, tx_valid, rx_ack, insn_valid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_insn_data", insn_data, 0);
      rst_n = 1;
      n0 = n_ready;
      xfer(0, A_ID, 0, 32'hDC0D_0001, 3, "id", lat);
      repeat (3) @(posedge clk);
      chk("id_once", n_ready - n0, 1);
      xfer(1, A_TX, 32'h1234_5678, 0, 3, "tx_wr1", lat);
      chk("tx_valid1", tx_valid, 1);
      chk("tx_data1", tx_data, 32'h1234_5678);
      xfer(1, A_TX, 32'hAAAA_5555, 0, 3, "tx_wr2", lat);
      chk("tx_data_kept", tx_data, 32'h1234_5678);
      xfer(0, A_STATUS, 0, 32'h0A, 3, "st_ovr", lat);
      pulse_tx_ack();
      chk("tx_acked", tx_valid, 0);
      xfer(0, A_TX, 0, 0, 3, "tx_rd0", lat);
      n0 = n_rxack;
      fork
         xfer(0, A_RX, 0, 32'hCAFE_F00D, 10, "rx_rd", lat);
         begin
            repeat (10) @(posedge clk);
            #1 rx_valid = 1; rx_data = 32'hCAFE_F00D;
            for (int k = 0; k < 100 && !rx_ack; k++) @(negedge clk);
            @(posedge clk); #1 rx_valid = 0;
         end
      join
      repeat (2) @(posedge clk);
      chk("rx_ack_once", n_rxack - n0, 1);
      n0 = n_rxack;
      xfer(0, A_RX, 0, 32'hDEAD_DEAD, -1, "rx_to", lat);
      chk("rx_to_lat", lat >= 64 && lat <= 68, 1);
      chk("rx_to_noack", n_rxack - n0, 0);
      xfer(0, A_STATUS, 0, 32'h28, 3, "st_to", lat);
      xfer(1, A_CTRL, 32'h1, 0, 3, "ctrl_halt", lat);
      chk("halt_set", halt, 1);
      xfer(0, A_CTRL, 0, 32'h1, 3, "ctrl_rd", lat);
      xfer(1, A_INSN, 32'h13, 0, 3, "insn_nothalt", lat);
      chk("insn_dropped", insn_valid, 0);
      xfer(0, A_STATUS, 0, 32'h38, 3, "st_err", lat);
      chk("halt_held", halt, 1);
      core_halted = 1;
      @(posedge clk); #1;
      chk("halt_clr", halt, 0);
      xfer(1, A_INSN, 32'h13, 0, 3, "insn_ok", lat);
      chk("insn_valid", insn_valid, 1);
      chk("insn_data", insn_data, 32'h13);
      xfer(0, A_STATUS, 0, 32'h39, 3, "st_halted", lat);
      @(posedge clk); #1 insn_ack = 1;
      @(posedge clk); #1 insn_ack = 0;
      chk("insn_acked", insn_valid, 0);
      core_halted = 0;
      xfer(1, A_CTRL, 32'h1, 0, 3, "ctrl_halt2", lat);
      n0 = n_resume;
      xfer(1, A_CTRL, 32'h3, 0, 3, "ctrl_resume", lat);
      chk("resume_once", n_resume - n0, 1);
      chk("halt_resumed", halt, 0);
      n0 = n_step;
      xfer(1, A_CTRL, 32'h4, 0, 3, "ctrl_step", lat);
      chk("step_once", n_step - n0, 1);
      xfer(1, A_CTRL, 32'h8000_0000, 0, 3, "ctrl_clr", lat);
      xfer(0, A_STATUS, 0, 32'h0, 3, "st_clr", lat);
      xfer(1, A_TX, 32'h1111_1111, 0, 3, "tx_a", lat);
      fork
         xfer(1, A_TX, 32'h2222_2222, 0, 3, "tx_b", lat);
         begin
            repeat (3) @(posedge clk);
            #1 tx_ack = 1;
            @(posedge clk); #1 tx_ack = 0;
         end
      join
      chk("tx_collide_data", tx_data, 32'h2222_2222);
      chk("tx_collide_valid", tx_valid, 1);
      xfer(0, A_STATUS, 0, 32'h02, 3, "st_collide", lat);
      pulse_tx_ack();
      xfer(1, 5'd7, 32'h5A5A_5A5A, 0, 3, "unmap_wr", lat);
      xfer(0, 5'd7, 0, 0, 3, "unmap_rd", lat);
      xfer(1, A_CTRL, 32'h1, 0, 3, "pre_rst_halt", lat);
      xfer(1, A_TX, 32'h5, 0, 3, "pre_rst_tx", lat);
      n0 = n_ready;
      @(posedge clk); #1;
      sel = 1; addr = A_RX; wr = 0;
      repeat (2) @(posedge clk);
      #1 sel = 0;
      repeat (4) @(posedge clk);
      #3 rst_n = 0;
      #1;
      chk("rst_mid_ctl", {ready, halt, resume, step, tx_valid, rx_ack, insn_valid}, 0);
      chk("rst_mid_rdata", rdata, 0);
      chk("rst_mid_tx_data", tx_data, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_noready", n_ready - n0, 0);
      rst_n = 1;
      xfer(0, A_ID, 0, 32'hDC0D_0001, 3, "id_after_rst", lat);
      repeat (3) @(posedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
